// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the sequential divider.
//   div_state_t : controller states (IDLE, CALC, DONE)
//   cnt_width() : iteration counter width for a given operand width
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // The counter has to be able to hold nb_bit itself.
   function automatic int cnt_width(input int nb_bit);
      return $clog2(nb_bit + 1);
   endfunction

endpackage

// File: rtl/subtractor_n.sv
// subtractor_n: combinational unsigned subtractor.
//   a_i, b_i  : nb_bit-wide unsigned operands
//   diff_o    : a_i - b_i, modulo 2^nb_bit
//   borrow_o  : 1 when a_i < b_i
module subtractor_n #(
   parameter int nb_bit = 8
) (
   input  logic [nb_bit-1:0] a_i,
   input  logic [nb_bit-1:0] b_i,
   output logic [nb_bit-1:0] diff_o,
   output logic              borrow_o
);

   // One extra bit on top catches the borrow out of the MSB.
   assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/divider_seq_n.sv
// divider_seq_n: sequential unsigned restoring divider, one quotient bit per
// clock, MSB first, using a single subtractor_n of width nb_bit+1.
//   clk_i, rstn_i          : clock, synchronous active-low reset
//   start_i                : request, taken only while ready_o is high
//   dividend_i, divisor_i  : operands, sampled at acceptance
//   ready_o                : high in IDLE
//   done_o                 : one-cycle pulse, results valid
//   quotient_o, remainder_o: registered results, held until next start
//   div_by_zero_o          : registered, accepted divisor was zero
module divider_seq_n
   import divider_pkg::*;
#(
   parameter int nb_bit = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic [nb_bit-1:0] dividend_i,
   input  logic [nb_bit-1:0] divisor_i,
   output logic              ready_o,
   output logic              done_o,
   output logic [nb_bit-1:0] quotient_o,
   output logic [nb_bit-1:0] remainder_o,
   output logic              div_by_zero_o
);

   localparam int CW = cnt_width(nb_bit);
   localparam logic [CW-1:0] LAST = CW'(nb_bit - 1);

   div_state_t        state;
   logic [CW-1:0]     cnt;
   logic [nb_bit:0]   rem_r;      // partial remainder R
   logic [nb_bit-1:0] q_work;     // dividend shifts out, quotient shifts in
   logic [nb_bit-1:0] divisor_r;

   logic [nb_bit:0]   shifted;
   logic [nb_bit:0]   diff;
   logic              borrow;
   logic [nb_bit:0]   rem_next;
   logic [nb_bit-1:0] q_next;

   // R < divisor after every step, so R's top bit is always zero and is
   // shifted out unused.
   logic unused_rem_top;
   assign unused_rem_top = rem_r[nb_bit];

   assign shifted = {rem_r[nb_bit-1:0], q_work[nb_bit-1]};

   subtractor_n #(.nb_bit(nb_bit + 1)) u_sub (
      .a_i      (shifted),
      .b_i      ({1'b0, divisor_r}),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // Restore on borrow: keep the shifted value and emit a 0 quotient bit.
   assign rem_next = borrow ? shifted : diff;
   assign q_next   = {q_work[nb_bit-2:0], ~borrow};

   // Both flags decode straight from the state register.
   assign ready_o = (state == IDLE);
   assign done_o  = (state == DONE);

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state         <= IDLE;
         cnt           <= '0;
         rem_r         <= '0;
         q_work        <= '0;
         divisor_r     <= '0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  q_work        <= dividend_i;
                  divisor_r     <= divisor_i;
                  rem_r         <= '0;
                  cnt           <= '0;
                  div_by_zero_o <= 1'b0;
                  if (divisor_i == '0) begin
                     quotient_o    <= '1;
                     remainder_o   <= dividend_i;
                     div_by_zero_o <= 1'b1;
                     state         <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem_r  <= rem_next;
               q_work <= q_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient_o  <= q_next;
                  remainder_o <= rem_next[nb_bit-1:0];
                  state       <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_seq_n.sv
// tb_divider_seq_n: scoreboard bench for divider_seq_n (nb_bit = 8).
module tb_divider_seq_n;

   localparam int NB = 8;

   typedef struct {
      int q;
      int r;
      int z;
      int cyc;
      string tag;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          start_i = 1'b0;
   logic [NB-1:0] dividend_i = '0;
   logic [NB-1:0] divisor_i = '0;
   logic          ready_o;
   logic          done_o;
   logic [NB-1:0] quotient_o;
   logic [NB-1:0] remainder_o;
   logic          div_by_zero_o;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t sb[$];

   divider_seq_n #(.nb_bit(NB)) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .ready_o       (ready_o),
      .done_o        (done_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding request.
   always @(negedge clk_i) begin
      if (rstn_i && done_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_quot"}, int'(quotient_o), e.q);
            chk({e.tag, "_rem"},  int'(remainder_o), e.r);
            chk({e.tag, "_dbz"},  int'(div_by_zero_o), e.z);
            chk({e.tag, "_lat"},  cyc, e.cyc);
         end
      end
   end

   // Wait for ready, pulse start across one edge (E0), optionally push the
   // expected result. Returns just after E0.
   task automatic issue(input string tag, input int a, input int b,
                        input int q, input int r, input int z, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk_i);
      while (!ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) chk({tag, "_ready_timeout"}, 0, 1);
      dividend_i = NB'(a);
      divisor_i  = NB'(b);
      start_i    = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (push) begin
         e.q   = q;
         e.r   = r;
         e.z   = z;
         e.cyc = cyc + ((b == 0) ? 0 : NB);
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || !ready_o) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_outstanding"}, sb.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   int dvd_tab[11] = '{0, 1, 2, 3, 7, 100, 127, 128, 200, 254, 255};
   int dvs_tab[11] = '{0, 1, 2, 3, 7, 15, 16, 100, 128, 254, 255};

   initial begin
      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_done",  int'(done_o), 0);
      chk("rst_quot",  int'(quotient_o), 0);
      chk("rst_rem",   int'(remainder_o), 0);
      chk("rst_dbz",   int'(div_by_zero_o), 0);

      // Main function
      issue("d200_7", 200, 7, 28, 4, 0, 1'b1);
      @(negedge clk_i);
      chk("calc_ready_low", int'(ready_o), 0);
      drain("d200_7");
      issue("d5_0", 5, 0, 255, 5, 1, 1'b1);
      drain("d5_0");
      issue("d255_1",   255, 1,   255, 0, 0, 1'b1);
      issue("d3_200",   3,   200, 0,   3, 0, 1'b1);
      issue("d255_255", 255, 255, 1,   0, 0, 1'b1);
      issue("d0_5",     0,   5,   0,   0, 0, 1'b1);
      issue("d0_0",     0,   0,   255, 0, 1, 1'b1);
      issue("d128_16",  128, 16,  8,   0, 0, 1'b1);
      drain("boundary");
      chk("hold_quot", int'(quotient_o), 8);

      // start_i during CALC is ignored
      issue("d50_3", 50, 3, 16, 2, 0, 1'b1);
      repeat (2) @(negedge clk_i);
      dividend_i = 8'd100;
      divisor_i  = 8'd9;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      drain("ignored_start");
      repeat (12) @(negedge clk_i);

      // Reset during CALC iteration 4 aborts with no done_o
      issue("abort", 50, 3, 0, 0, 0, 1'b0);
      repeat (4) @(negedge clk_i);
      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      #1;
      chk("abort_ready", int'(ready_o), 1);
      chk("abort_done",  int'(done_o), 0);
      chk("abort_quot",  int'(quotient_o), 0);
      chk("abort_rem",   int'(remainder_o), 0);
      chk("abort_dbz",   int'(div_by_zero_o), 0);
      repeat (12) @(negedge clk_i);
      issue("d10_3", 10, 3, 3, 1, 0, 1'b1);
      drain("d10_3");

      // Back-to-back sweep over boundary-heavy operand sets
      foreach (dvd_tab[i]) begin
         foreach (dvs_tab[j]) begin
            int a;
            int b;
            a = dvd_tab[i];
            b = dvs_tab[j];
            if (b == 0) issue("sweep", a, b, 255, a, 1, 1'b1);
            else        issue("sweep", a, b, a / b, a % b, 0, 1'b1);
         end
      end
      drain("sweep");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
